// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_e     : controller states (IDLE / RUN / DONE)
//   ADDER_WIDTH : default operand and result width
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned ADDER_WIDTH = 4;

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// Single-bit full adder, purely combinational.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one bit per
// clock, LSB first, with a start/busy/done handshake.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request an operation (accepted in IDLE or DONE)
//   sub       : 0 = a+b, 1 = a-b (captured with start)
//   a, b      : operands (captured with start)
//   busy      : operation in progress
//   done      : one-cycle pulse, result/c_out/overflow valid
//   result    : sum or difference modulo 2^WIDTH
//   c_out     : final carry (subtract: 1 = no borrow)
//   overflow  : two's-complement signed overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == ST_RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB position.
      if (cnt_q == CNT_PRE) cmsb_d = fa_c;
      if (cnt_q == CNT_LAST) begin
        cout_d = fa_c;
        ovf_d  = cmsb_q ^ fa_c;
      end
    end else if (start) begin
      // Subtract as a + ~b + 1: invert B and seed the carry with sub.
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub;
      cnt_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    result   = res_q;
    c_out    = cout_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int ia, input int ib, input bit is);
    exp_t e;
    int full, sa, sb, sr;
    full = is ? (ia - ib + 16) : (ia + ib);
    sa   = (ia >= 8) ? ia - 16 : ia;
    sb   = (ib >= 8) ? ib - 16 : ib;
    sr   = is ? (sa - sb) : (sa + sb);
    e.r  = W'(full % 16);
    e.c  = (full >= 16);
    e.v  = (sr > 7) || (sr < -8);
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (prev_done) begin
        total++; bad++;
        $display("FAIL done_width: done high two cycles in a row");
      end
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got result=%0h with no operation pending", result);
      end else begin
        e = sbq.pop_front();
        check("op_result{r,c,v}", {26'd0, result, c_out, overflow}, {26'd0, e.r, e.c, e.v});
      end
    end
    prev_done = done;
  end

  // Drive at a negedge; returns at the next negedge (first RUN cycle if accepted).
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       input bit do_push, input exp_t e);
    a = ia; b = ib; sub = is; start = 1'b1;
    if (do_push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required within 20", cyc);
    end
  endtask

  initial begin
    int cyc, bc, gap;
    exp_t e;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, busy, done, result, c_out, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with constant expectations
    issue(4'd5, 4'd3, 1'b0, 1, exp_t'{4'd8, 1'b0, 1'b1});
    wait_done(cyc, bc);
    check("latency_5p3", cyc, 4);
    check("busy_cycles_5p3", bc, 4);
    @(negedge clk);
    check("done_drops", {31'd0, done}, 32'd0);
    issue(4'd15, 4'd1, 1'b0, 1, exp_t'{4'd0, 1'b1, 1'b0});
    wait_done(cyc, bc); @(negedge clk);
    issue(4'd3, 4'd5, 1'b1, 1, exp_t'{4'd14, 1'b0, 1'b0});
    wait_done(cyc, bc); @(negedge clk);
    issue(4'd8, 4'd1, 1'b1, 1, exp_t'{4'd7, 1'b1, 1'b1});
    wait_done(cyc, bc); @(negedge clk);
    issue(4'd0, 4'd0, 1'b1, 1, exp_t'{4'd0, 1'b1, 1'b0});
    wait_done(cyc, bc); @(negedge clk);

    // start during RUN is ignored
    issue(4'd6, 4'd2, 1'b0, 1, exp_t'{4'd8, 1'b0, 1'b1});
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    check("latency_ignored_start", cyc, 2);
    repeat (3) @(negedge clk);
    check("no_second_op", {31'd0, busy}, 32'd0);

    // Reset mid-RUN aborts with no done pulse
    issue(4'd7, 4'd7, 1'b0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_midrun", {25'd0, busy, done, result, c_out, overflow}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Reset wins over simultaneous start
    rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3; sub = 1'b0;
    @(negedge clk);
    check("rst_beats_start", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Exhaustive back-to-back: next start presented during DONE
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] ia, ib;
      logic is;
      ia = W'(i % 16);
      ib = W'((i / 16) % 16);
      is = (i >= 256);
      issue(ia, ib, is, 1, model(int'(ia), int'(ib), is));
      if (i > 0) check("b2b_no_gap", {31'd0, busy}, 32'd1);
      wait_done(cyc, bc);
    end
    @(negedge clk);

    // Randomized operations with random idle gaps
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ia, ib;
      logic is;
      ia = W'($urandom_range(15, 0));
      ib = W'($urandom_range(15, 0));
      is = 1'($urandom_range(1, 0));
      issue(ia, ib, is, 1, model(int'(ia), int'(ib), is));
      wait_done(cyc, bc);
      check("latency_rand", cyc, 4);
      gap = $urandom_range(3, 0);
      repeat (gap) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
